// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Optional grant counters are built when MEM_ARB_CNT_EN is defined.
//
// state  | meaning
// IDLE   | no transfer in progress; sample requests and pick an owner
// ACCESS | memory strobes asserted for MEM_LATENCY cycles
// RESP   | strobes low; one-cycle ack to the owner
module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_adrs,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_read,
  output logic          mem_write
`ifdef MEM_ARB_CNT_EN
  ,
  output logic [15:0]   grant_cnt0,
  output logic [15:0]   grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic          last_q, last_d;
  logic          sel;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] adrs_q, adrs_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      adrs_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      adrs_q   <= adrs_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    adrs_d   = adrs_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    // On a tie the port that was not served last wins.
    sel      = (req0 && req1) ? ~last_q : req1;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = sel;
          we_d    = sel ? we1 : we0;
          adrs_d  = sel ? addr1 : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = (state_q != IDLE) && !owner_q;
  assign gnt1      = (state_q != IDLE) &&  owner_q;
  assign ack0      = (state_q == RESP) && !owner_q;
  assign ack1      = (state_q == RESP) &&  owner_q;
  assign mem_read  = (state_q == ACCESS) && !we_q;
  assign mem_write = (state_q == ACCESS) &&  we_q;
  assign mem_adrs  = adrs_q;
  assign mem_wdata = wdata_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

`ifdef MEM_ARB_CNT_EN
  logic [15:0] gcnt0_q, gcnt0_d;
  logic [15:0] gcnt1_q, gcnt1_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (ack0) gcnt0_d = gcnt0_q + 16'd1;
    if (ack1) gcnt1_d = gcnt1_q + 16'd1;
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LATENCY=1, one with 3,
// sharing a small behavioural memory.
module tb_mem_arbiter;
  logic clk, rst;
  int n_cmp, n_err;

  logic        req0_a, we0_a, req1_a, we1_a, ack0_a, gnt0_a, ack1_a, gnt1_a;
  logic [7:0]  addr0_a, addr1_a, mem_adrs_a;
  logic [31:0] wdata0_a, wdata1_a, rdata0_a, rdata1_a, mem_wdata_a, mem_rdata_a;
  logic        mem_read_a, mem_write_a;

  logic        req0_b, we0_b, req1_b, we1_b, ack0_b, gnt0_b, ack1_b, gnt1_b;
  logic [7:0]  addr0_b, addr1_b, mem_adrs_b;
  logic [31:0] wdata0_b, wdata1_b, rdata0_b, rdata1_b, mem_wdata_b, mem_rdata_b;
  logic        mem_read_b, mem_write_b;

`ifdef MEM_ARB_CNT_EN
  logic [15:0] gc0_a, gc1_a, gc0_b, gc1_b;
`endif

  logic [31:0] mem [0:255];

  mem_arbiter #(.MEM_LATENCY(1), .AW(8), .DW(32)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a),
    .ack0(ack0_a), .gnt0(gnt0_a), .rdata0(rdata0_a),
    .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a),
    .ack1(ack1_a), .gnt1(gnt1_a), .rdata1(rdata1_a),
    .mem_adrs(mem_adrs_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a)
`ifdef MEM_ARB_CNT_EN
    , .grant_cnt0(gc0_a), .grant_cnt1(gc1_a)
`endif
  );

  mem_arbiter #(.MEM_LATENCY(3), .AW(8), .DW(32)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .we0(we0_b), .addr0(addr0_b), .wdata0(wdata0_b),
    .ack0(ack0_b), .gnt0(gnt0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(we1_b), .addr1(addr1_b), .wdata1(wdata1_b),
    .ack1(ack1_b), .gnt1(gnt1_b), .rdata1(rdata1_b),
    .mem_adrs(mem_adrs_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b)
`ifdef MEM_ARB_CNT_EN
    , .grant_cnt0(gc0_b), .grant_cnt1(gc1_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only dut_a writes; both read combinationally.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h30] <= 32'hCAFEF00D;
    end else if (mem_write_a) begin
      mem[mem_adrs_a] <= mem_wdata_a;
    end
  end
  assign mem_rdata_a = mem[mem_adrs_a];
  assign mem_rdata_b = mem[mem_adrs_b];

  task automatic test_reset;
    @(negedge clk);
    n_cmp++;
    if ({ack0_a, ack1_a, gnt0_a, gnt1_a, mem_read_a, mem_write_a} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {ack0_a, ack1_a, gnt0_a, gnt1_a, mem_read_a, mem_write_a});
    end
    n_cmp++;
    if (mem_adrs_a !== 8'h0 || mem_wdata_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mem: got adrs=%h wdata=%h want 0/0", mem_adrs_a, mem_wdata_a);
    end
    n_cmp++;
    if (rdata0_a !== 32'h0 || rdata1_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0_a, rdata1_a);
    end
  endtask

  task automatic test_single_read;
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 8'h10;
    @(negedge clk);
    n_cmp++;
    if ({mem_read_a, mem_write_a, gnt0_a, gnt1_a, ack0_a} !== 5'b10100) begin
      n_err++;
      $display("FAIL rd_access: got %b want 10100",
               {mem_read_a, mem_write_a, gnt0_a, gnt1_a, ack0_a});
    end
    n_cmp++;
    if (mem_adrs_a !== 8'h10) begin
      n_err++;
      $display("FAIL rd_adrs: got %h want 10", mem_adrs_a);
    end
    @(negedge clk);
    n_cmp++;
    if ({ack0_a, ack1_a, gnt0_a, gnt1_a, mem_read_a} !== 5'b10100) begin
      n_err++;
      $display("FAIL rd_resp: got %b want 10100", {ack0_a, ack1_a, gnt0_a, gnt1_a, mem_read_a});
    end
    n_cmp++;
    if (rdata0_a !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rd_data: got %h want deadbeef", rdata0_a);
    end
    req0_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack0_a, gnt0_a, mem_read_a} !== 3'b000 || mem_adrs_a !== 8'h10) begin
      n_err++;
      $display("FAIL rd_idle: got ctl=%b adrs=%h want 000/10",
               {ack0_a, gnt0_a, mem_read_a}, mem_adrs_a);
    end
  endtask

  task automatic test_write_read;
    req1_a = 1'b1; we1_a = 1'b1; addr1_a = 8'h20; wdata1_a = 32'h12345678;
    @(negedge clk);
    n_cmp++;
    if ({mem_write_a, mem_read_a, gnt1_a, gnt0_a} !== 4'b1010 || mem_wdata_a !== 32'h12345678) begin
      n_err++;
      $display("FAIL wr_access: got %b wdata=%h want 1010/12345678",
               {mem_write_a, mem_read_a, gnt1_a, gnt0_a}, mem_wdata_a);
    end
    @(negedge clk);
    n_cmp++;
    if ({ack1_a, ack0_a, mem_write_a} !== 3'b100 || rdata1_a !== 32'h0) begin
      n_err++;
      $display("FAIL wr_resp: got %b rdata1=%h want 100/0", {ack1_a, ack0_a, mem_write_a}, rdata1_a);
    end
    we1_a = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_read_a, mem_write_a, gnt1_a, ack1_a} !== 4'b0000) begin
      n_err++;
      $display("FAIL wr_idle: got %b want 0000", {mem_read_a, mem_write_a, gnt1_a, ack1_a});
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_read_a, gnt1_a} !== 2'b11 || mem_adrs_a !== 8'h20) begin
      n_err++;
      $display("FAIL rb_access: got %b adrs=%h want 11/20", {mem_read_a, gnt1_a}, mem_adrs_a);
    end
    @(negedge clk);
    n_cmp++;
    if (ack1_a !== 1'b1 || rdata1_a !== 32'h12345678) begin
      n_err++;
      $display("FAIL rb_data: got ack=%b rdata1=%h want 1/12345678", ack1_a, rdata1_a);
    end
    n_cmp++;
    if (rdata0_a !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rb_rdata0_kept: got %h want deadbeef", rdata0_a);
    end
    req1_a = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp;
    int m;
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 8'h10;
    req1_a = 1'b1; we1_a = 1'b0; addr1_a = 8'h20;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      m = c % 6;
      exp = {m == 2, m == 5, m == 1 || m == 2, m == 4 || m == 5};
      n_cmp++;
      if ({ack0_a, ack1_a, gnt0_a, gnt1_a} !== exp) begin
        n_err++;
        $display("FAIL rr_cycle%0d: got ack0,ack1,gnt0,gnt1=%b want %b",
                 c, {ack0_a, ack1_a, gnt0_a, gnt1_a}, exp);
      end
    end
    req0_a = 1'b0; req1_a = 1'b0;
    n_cmp++;
    if (rdata0_a !== 32'hDEADBEEF || rdata1_a !== 32'h12345678) begin
      n_err++;
      $display("FAIL rr_rdata: got %h/%h want deadbeef/12345678", rdata0_a, rdata1_a);
    end
    @(negedge clk);
  endtask

  task automatic test_latency;
    logic [1:0] exp;
    req0_b = 1'b1; we0_b = 1'b0; addr0_b = 8'h30;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp = {c >= 1 && c <= 3, c == 4};
      n_cmp++;
      if ({mem_read_b, ack0_b} !== exp) begin
        n_err++;
        $display("FAIL lat_cycle%0d: got mem_read,ack0=%b want %b", c, {mem_read_b, ack0_b}, exp);
      end
      if (c == 4) begin
        req0_b = 1'b0;
        n_cmp++;
        if (rdata0_b !== 32'hCAFEF00D || mem_adrs_b !== 8'h30) begin
          n_err++;
          $display("FAIL lat_data: got rdata0=%h adrs=%h want cafef00d/30", rdata0_b, mem_adrs_b);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    req0_a = 1'b1; we0_a = 1'b0; addr0_a = 8'h10;
    @(negedge clk);
    n_cmp++;
    if ({mem_read_a, gnt0_a} !== 2'b11) begin
      n_err++;
      $display("FAIL abort_pre: got %b want 11", {mem_read_a, gnt0_a});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({mem_read_a, gnt0_a, ack0_a, gnt1_a, ack1_a} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_drop: got %b want 00000", {mem_read_a, gnt0_a, ack0_a, gnt1_a, ack1_a});
    end
    @(negedge clk);
    n_cmp++;
    if (ack0_a !== 1'b0 || gnt0_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_noack: got ack0=%b gnt0=%b want 0/0", ack0_a, gnt0_a);
    end
    req1_a = 1'b1; we1_a = 1'b0; addr1_a = 8'h20;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({gnt0_a, gnt1_a, mem_read_a} !== 3'b101) begin
      n_err++;
      $display("FAIL abort_prio: got gnt0,gnt1,rd=%b want 101", {gnt0_a, gnt1_a, mem_read_a});
    end
    @(negedge clk);
    n_cmp++;
    if ({ack0_a, ack1_a} !== 2'b10) begin
      n_err++;
      $display("FAIL abort_ack: got %b want 10", {ack0_a, ack1_a});
    end
    req0_a = 1'b0; req1_a = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_CNT_EN
    n_cmp++;
    if (gc0_a !== 16'd1 || gc1_a !== 16'd0) begin
      n_err++;
      $display("FAIL cnt_after_reset: got %0d/%0d want 1/0", gc0_a, gc1_a);
    end
`endif
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0;
    req0_a = 0; we0_a = 0; addr0_a = 0; wdata0_a = 0;
    req1_a = 0; we1_a = 0; addr1_a = 0; wdata1_a = 0;
    req0_b = 0; we0_b = 0; addr0_b = 0; wdata0_b = 0;
    req1_b = 0; we1_b = 0; addr1_b = 0; wdata1_b = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_single_read;
    test_write_read;
    test_back_to_back;
    test_latency;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
